mfp_eic_gen2: RTL and testbench
===============================

# mfp_eic_gen2

Parametrised second-generation external interrupt controller for the MIPSfpga CPU wrapper in EIC mode. Collects up to 64 interrupt sources, with per-channel edge/level sense, mask and 6-bit priority, and selects the winner. Presents the requested IPL, vector and offset to the core, and retires edge requests on the core's `SI_IAck`. A simple word-addressed register port, bridged from the AHB-Lite matrix, configures the block.

## Interface
- `N_IRQ`, 32: number of channels, 1..64.
- `OFFSET_STEP`, 17'h10: vector spacing; `SI_Offset` = vector * `OFFSET_STEP`, truncated to 17 bits.
- `SI_ClkIn` in 1: the block's one clock; all logic is on its rising edge.
- `SI_Reset` in 1: synchronous, active-high reset.
- `irq_in` in `N_IRQ`: raw interrupt sources, asynchronous.
- `cfg_we` in 1: register write strobe.
- `cfg_addr` in 8: word address.
- `cfg_wdata` in 32: write data.
- `cfg_rdata` out 32: read data, registered, valid 1 cycle after the address.
- `SI_IAck` in 1: core acknowledge pulse.
- `SI_IVN` in 6: vector being acknowledged.
- `SI_Int` out 8: `[5:0]` carry the requested IPL (RIPL); `[7:6]` are 0.
- `SI_EICVector` out 6: winning channel index.
- `SI_Offset` out 17: vector offset.
- `SI_EISS` out 4: constant 0.
- `SI_EICPresent` out 1: constant 1.
- `irq_pending` out `N_IRQ`: pending vector, for debug.

## Operation
- Register map, with bank k in 0..1 covering channels 32k..32k+31:
  - 0x00+k EDGE: 1 = rising-edge sensitive, 0 = level.
  - 0x04+k MASK: 1 = enabled.
  - 0x08+k PEND: reads the pending bits; writing 1 clears an edge bit.
  - 0x40+i PRIO[i]: bits `[5:0]`.
- Reads of unimplemented addresses or channels return 0; writes to them are ignored.
- Pending bit per channel:
  - Edge channel: set on a synchronized 0→1 transition; cleared by PEND write-1 or by an ack where `SI_IAck`=1 and `SI_IVN`=i.
  - Level channel: pending equals the synchronized input; PEND writes and acks have no effect.
- Set and clear on the same edge: set wins, so no edge is lost.
- Candidate: pending & mask & (PRIO != 0).
- Winner: the highest PRIO among candidates; ties go to the lowest index.
- No candidate: RIPL=0, vector=0, offset=0.
- Outputs are registered. The core samples RIPL against Status.IPL; the block does not track nesting.
- Changing MASK or PRIO while a request is presented takes effect on the next selection cycle.

## Timing
- Reset state:
  - EDGE, MASK, PEND, PRIO and the synchronizer flops all 0.
  - `SI_Int`, `SI_EICVector`, `SI_Offset`, `cfg_rdata` = 0; `SI_EISS`=0; `SI_EICPresent`=1.
- Reset asserted mid-request drops RIPL to 0 on the next edge.
- Request latency with the synchronizer compiled in, counting from the first edge sampling `irq_in` high:
  - edges 1 and 2: synchronizer;
  - edge 3: pending set;
  - edge 4: `SI_Int`, vector and offset valid.
- Request latency without the synchronizer: pending set at edge 1, outputs valid at edge 2.
- Ack: the pending bit clears on the edge sampling `SI_IAck`=1. The next winner, or 0, is presented 1 edge later.
- A `cfg_we` PEND clear follows the same timing as an ack.
- `SI_IAck` with an `SI_IVN` that is ≥`N_IRQ` or names a level channel is ignored.

## Configuration
- `MFP_EIC_GEN2_SYNC_EN`:
  - Defined: 2-flop synchronizer on every `irq_in` bit, with the latency above.
  - Undefined: `irq_in` is treated as synchronous to `SI_ClkIn` and fed straight to the edge detector and pending logic, removing 2 cycles of latency.

## Structure
- Shared package `mfp_eic_gen2_pkg`:
  - register offsets `EDGE_BASE`, `MASK_BASE`, `PEND_BASE`, `PRIO_BASE`;
  - `IPL_W`=6, `VEC_W`=6, `OFFSET_W`=17;
  - max channels 64.
- One sub-module, `mfp_eic_prio_sel`: a combinational tournament tree over `N_IRQ` candidates that outputs the winning index, its priority and a valid flag. The top level registers its outputs.

## Test plan
- Reset: after reset, `SI_Int`=0, `SI_EICVector`=0, `SI_EICPresent`=1; `cfg_rdata` reads 0 at 0x04.
- Edge request: MASK0=0x8, EDGE0=0x8, PRIO[3]=5; pulse `irq_in[3]` for 1 cycle. RIPL=5 and vector=3 at edge 4; `SI_Offset`=0x30. Ack with `SI_IVN`=3 → RIPL=0 one edge later.
- Priority and tie: channels 2, 7 and 9 at level, with PRIO 4, 9 and 9 → vector=7, RIPL=9. Drop channel 7 → vector=9.
- Simultaneous events: edge channel 5 is acked on the same edge a new rising edge arrives → PEND bit 5 stays 1 and vector 5 is re-presented.
- High bank: `N_IRQ`=64, channel 40 edge, PRIO=63 → vector=40, RIPL=63. A write of 0x100 to 0x09 clears it.
- Reset mid-request: assert `SI_Reset` while RIPL=5 → RIPL=0 on the next edge and all PRIO read 0.

Source files
------------

// File: rtl/mfp_eic_gen2_pkg.sv
// Shared definitions for the mfp_eic_gen2 external interrupt controller:
// register map offsets, field widths and the priority-selection record.
package mfp_eic_gen2_pkg;

  localparam int MAX_IRQ  = 64;
  localparam int IPL_W    = 6;
  localparam int VEC_W    = 6;
  localparam int OFFSET_W = 17;

  // Word addresses; EDGE/MASK/PEND occupy base+0 (channels 0..31) and base+1 (32..63).
  localparam logic [7:0] EDGE_BASE = 8'h00;
  localparam logic [7:0] MASK_BASE = 8'h04;
  localparam logic [7:0] PEND_BASE = 8'h08;
  localparam logic [7:0] PRIO_BASE = 8'h40;

  // One contender in the priority tournament.
  typedef struct packed {
    logic             valid;
    logic [IPL_W-1:0] prio;
    logic [VEC_W-1:0] idx;
  } sel_t;

  // Left operand always covers lower channel indices, so '>=' gives ties to the lower index.
  function automatic sel_t sel_pick(input sel_t l, input sel_t r);
    if (l.valid && (!r.valid || l.prio >= r.prio)) return l;
    return r;
  endfunction

  // 64-bit lane mask selected by a write to one of the two words of a banked register.
  function automatic logic [MAX_IRQ-1:0] bank_sel(input logic [7:0] addr, input logic [7:0] base);
    if (addr == base)        return {32'h0000_0000, 32'hFFFF_FFFF};
    if (addr == base + 8'd1) return {32'hFFFF_FFFF, 32'h0000_0000};
    return '0;
  endfunction

endpackage

// File: rtl/mfp_eic_prio_sel.sv
// Combinational tournament tree: picks the highest-priority valid candidate,
// lowest index on ties. The caller registers the result.
module mfp_eic_prio_sel
  import mfp_eic_gen2_pkg::*;
#(
  parameter int N_IRQ = 32
) (
  input  logic [N_IRQ-1:0]       cand,
  input  logic [N_IRQ*IPL_W-1:0] prio_flat,
  output logic                   win_valid,
  output logic [VEC_W-1:0]       win_idx,
  output logic [IPL_W-1:0]       win_prio
);

  // Leaf count rounded up to a power of two so every round pairs cleanly.
  localparam int P = (N_IRQ <= 1) ? 1 : (1 << $clog2(N_IRQ));

  logic [P-1:0]       cand_pad;
  logic [P*IPL_W-1:0] prio_pad;
  sel_t               winner;

  function automatic sel_t tournament(input logic [P-1:0] c, input logic [P*IPL_W-1:0] p);
    sel_t node [P];
    for (int i = 0; i < P; i++) begin
      node[i].valid = c[i];
      node[i].prio  = p[i*IPL_W +: IPL_W];
      node[i].idx   = VEC_W'(i);
    end
    // Each round halves the field; winners of pair (2j, 2j+1) move to slot j.
    for (int w = P / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        node[j] = sel_pick(node[2*j], node[2*j+1]);
      end
    end
    return node[0];
  endfunction

  // Pad the candidate set out to the tree width with empty slots, then run the tree.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can hold a value (latch).
    cand_pad = '0;
    prio_pad = '0;
    cand_pad[N_IRQ-1:0]       = cand;
    prio_pad[N_IRQ*IPL_W-1:0] = prio_flat;
    winner = tournament(cand_pad, prio_pad);
  end

  assign win_valid = winner.valid;
  assign win_idx   = winner.idx;
  assign win_prio  = winner.prio;

endmodule

// File: rtl/mfp_eic_gen2.sv
// Second-generation external interrupt controller for the MIPSfpga core in EIC mode.
// Up to 64 sources with per-channel edge/level sense, mask and 6-bit priority;
// presents RIPL/vector/offset to the core and retires edge requests on SI_IAck.
// Optional build macro MFP_EIC_GEN2_SYNC_EN inserts a 2-flop synchronizer on irq_in.
module mfp_eic_gen2
  import mfp_eic_gen2_pkg::*;
#(
  parameter int              N_IRQ       = 32,
  parameter logic [16:0]     OFFSET_STEP = 17'h10
) (
  input  logic               SI_ClkIn,
  input  logic               SI_Reset,
  input  logic [N_IRQ-1:0]   irq_in,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  input  logic               SI_IAck,
  input  logic [5:0]         SI_IVN,
  output logic [7:0]         SI_Int,
  output logic [5:0]         SI_EICVector,
  output logic [16:0]        SI_Offset,
  output logic [3:0]         SI_EISS,
  output logic               SI_EICPresent,
  output logic [N_IRQ-1:0]   irq_pending
);

  // Lanes that correspond to real channels; the rest stay 0 and read back as 0.
  localparam logic [MAX_IRQ-1:0] CH_MASK =
    (N_IRQ >= MAX_IRQ) ? {MAX_IRQ{1'b1}} : ((64'd1 << N_IRQ) - 64'd1);

  logic [N_IRQ-1:0]       irq_s;
  logic [MAX_IRQ-1:0]     irq_pad, irq_d, rise;
  logic [MAX_IRQ-1:0]     edge_r, mask_r, pend_r, pend_nxt;
  logic [IPL_W-1:0]       prio_r [MAX_IRQ];
  logic [MAX_IRQ-1:0]     wr_val, edge_wm, mask_wm, pend_wc, ack_clr;
  logic                   prio_we;
  logic [31:0]            rd_nxt;
  logic [N_IRQ-1:0]       cand;
  logic [N_IRQ*IPL_W-1:0] prio_flat;
  logic                   sel_valid;
  logic [VEC_W-1:0]       sel_idx;
  logic [IPL_W-1:0]       sel_prio;
  logic [OFFSET_W-1:0]    off_calc;
  logic [IPL_W-1:0]       ripl_r;
  logic [VEC_W-1:0]       vec_r;
  logic [OFFSET_W-1:0]    off_r;

`ifdef MFP_EIC_GEN2_SYNC_EN
  logic [N_IRQ-1:0] sync_q1, sync_q2;

  // Two-flop synchronizer for the asynchronous interrupt sources.
  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq_in;
`endif

  // Write decode, edge detect and next pending state for all 64 lanes.
  always_comb begin
    irq_pad = '0;
    irq_pad[N_IRQ-1:0] = irq_s;
    rise    = irq_pad & ~irq_d;
    wr_val  = {cfg_wdata, cfg_wdata};
    edge_wm = cfg_we ? (bank_sel(cfg_addr, EDGE_BASE) & CH_MASK) : '0;
    mask_wm = cfg_we ? (bank_sel(cfg_addr, MASK_BASE) & CH_MASK) : '0;
    pend_wc = cfg_we ? (bank_sel(cfg_addr, PEND_BASE) & wr_val) : '0;
    // Acks only retire edge channels; level lanes and unimplemented lanes have edge_r = 0.
    ack_clr = SI_IAck ? ((64'd1 << SI_IVN) & edge_r) : '0;
    // A new rising edge on the same clock as a clear keeps the request.
    pend_nxt = (edge_r & (rise | (pend_r & ~(pend_wc | ack_clr)))) | (~edge_r & irq_pad);
    prio_we  = cfg_we && (cfg_addr[7:6] == PRIO_BASE[7:6]) && (int'(cfg_addr[5:0]) < N_IRQ);
  end

  // Register read mux; unimplemented addresses and channels return 0.
  always_comb begin
    rd_nxt = '0;
    case (cfg_addr)
      EDGE_BASE:        rd_nxt = edge_r[31:0];
      EDGE_BASE + 8'd1: rd_nxt = edge_r[63:32];
      MASK_BASE:        rd_nxt = mask_r[31:0];
      MASK_BASE + 8'd1: rd_nxt = mask_r[63:32];
      PEND_BASE:        rd_nxt = pend_r[31:0];
      PEND_BASE + 8'd1: rd_nxt = pend_r[63:32];
      default: begin
        if (cfg_addr[7:6] == PRIO_BASE[7:6] && int'(cfg_addr[5:0]) < N_IRQ)
          rd_nxt = {{(32-IPL_W){1'b0}}, prio_r[cfg_addr[5:0]]};
      end
    endcase
  end

  // Candidate set for the selector: pending, enabled and non-zero priority.
  always_comb begin
    cand      = '0;
    prio_flat = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      cand[i]                    = pend_r[i] & mask_r[i] & (prio_r[i] != '0);
      prio_flat[i*IPL_W +: IPL_W] = prio_r[i];
    end
  end

  mfp_eic_prio_sel #(.N_IRQ(N_IRQ)) u_prio_sel (
    .cand      (cand),
    .prio_flat (prio_flat),
    .win_valid (sel_valid),
    .win_idx   (sel_idx),
    .win_prio  (sel_prio)
  );

  assign off_calc = {{(OFFSET_W-VEC_W){1'b0}}, sel_idx} * OFFSET_STEP;

  // Configuration registers, pending state and registered core-facing outputs.
  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      irq_d     <= '0;
      edge_r    <= '0;
      mask_r    <= '0;
      pend_r    <= '0;
      // NOTE: the priority array is reset explicitly; software may rely on PRIO reading 0.
      for (int i = 0; i < MAX_IRQ; i++) prio_r[i] <= '0;
      cfg_rdata <= '0;
      ripl_r    <= '0;
      vec_r     <= '0;
      off_r     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      irq_d     <= irq_pad;
      pend_r    <= pend_nxt;
      edge_r    <= (edge_r & ~edge_wm) | (wr_val & edge_wm);
      mask_r    <= (mask_r & ~mask_wm) | (wr_val & mask_wm);
      if (prio_we) prio_r[cfg_addr[5:0]] <= cfg_wdata[IPL_W-1:0];
      cfg_rdata <= rd_nxt;
      ripl_r    <= sel_valid ? sel_prio : '0;
      vec_r     <= sel_valid ? sel_idx  : '0;
      off_r     <= sel_valid ? off_calc : '0;
    end
  end

  assign SI_Int        = {2'b00, ripl_r};
  assign SI_EICVector  = vec_r;
  assign SI_Offset     = off_r;
  assign SI_EISS       = 4'h0;
  assign SI_EICPresent = 1'b1;
  assign irq_pending   = pend_r[N_IRQ-1:0];

endmodule

// File: tb/tb_mfp_eic_gen2.sv
// Self-checking bench for mfp_eic_gen2 (64 channels): register table vectors,
// directed multi-cycle sequences and a randomized run against a cycle model.
module tb_mfp_eic_gen2;

  localparam int N = 64;
`ifdef MFP_EIC_GEN2_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int LAT = D + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] irq;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        iack;
  logic [5:0]  ivn;
  logic [7:0]  si_int;
  logic [5:0]  si_vec;
  logic [16:0] si_off;
  logic [3:0]  si_eiss;
  logic        si_present;
  logic [63:0] pend;

  always #5 clk = ~clk;

  mfp_eic_gen2 #(.N_IRQ(N), .OFFSET_STEP(17'h10)) dut (
    .SI_ClkIn      (clk),
    .SI_Reset      (rst),
    .irq_in        (irq),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_rdata     (cfg_rdata),
    .SI_IAck       (iack),
    .SI_IVN        (ivn),
    .SI_Int        (si_int),
    .SI_EICVector  (si_vec),
    .SI_Offset     (si_off),
    .SI_EISS       (si_eiss),
    .SI_EICPresent (si_present),
    .irq_pending   (pend)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_edge, m_mask, m_pend;
  int          m_prio [64];
  logic [63:0] m_hist [$];
  logic [7:0]  e_int;
  logic [5:0]  e_vec;
  logic [16:0] e_off;
  logic [31:0] e_rd;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return m_edge[31:0];
      8'h01: return m_edge[63:32];
      8'h04: return m_mask[31:0];
      8'h05: return m_mask[63:32];
      8'h08: return m_pend[31:0];
      8'h09: return m_pend[63:32];
      default: ;
    endcase
    if (a >= 8'h40 && a < 8'h80) return 32'(m_prio[a[5:0]]);
    return 32'h0;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT is about to sample.
  task automatic model_edge();
    int bp, bi;
    logic [63:0] seen, prev, nxt;
    logic clr;
    if (rst) begin
      m_edge = '0; m_mask = '0; m_pend = '0;
      for (int i = 0; i < 64; i++) m_prio[i] = 0;
      e_int = '0; e_vec = '0; e_off = '0; e_rd = '0;
      m_hist.delete();
      repeat (D + 2) m_hist.push_back(64'h0);
      return;
    end
    bp = 0; bi = 0;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_mask[i] && m_prio[i] > bp) begin bp = m_prio[i]; bi = i; end
    e_int = 8'(bp);
    e_vec = 6'(bi);
    e_off = 17'(bi * 16);
    e_rd  = m_read(cfg_addr);
    m_hist.push_back(irq);
    seen = m_hist[m_hist.size() - 1 - D];
    prev = m_hist[m_hist.size() - 2 - D];
    void'(m_hist.pop_front());
    nxt = m_pend;
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) begin
        clr = (cfg_we && cfg_addr == 8'(8 + i / 32) && cfg_wdata[i % 32]) || (iack && int'(ivn) == i);
        nxt[i] = (seen[i] && !prev[i]) || (m_pend[i] && !clr);
      end else begin
        nxt[i] = seen[i];
      end
    end
    m_pend = nxt;
    if (cfg_we) begin
      case (cfg_addr)
        8'h00: m_edge[31:0]  = cfg_wdata;
        8'h01: m_edge[63:32] = cfg_wdata;
        8'h04: m_mask[31:0]  = cfg_wdata;
        8'h05: m_mask[63:32] = cfg_wdata;
        default: if (cfg_addr >= 8'h40 && cfg_addr < 8'h80) m_prio[cfg_addr[5:0]] = int'(cfg_wdata[5:0]);
      endcase
    end
  endtask

  // One clock: update model, let the DUT clock, compare #1 after the edge.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("model_ripl",  64'(si_int),    64'(e_int));
    check("model_vec",   64'(si_vec),    64'(e_vec));
    check("model_off",   64'(si_off),    64'(e_off));
    check("model_rdata", 64'(cfg_rdata), 64'(e_rd));
    check("model_pend",  pend,           m_pend);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cycle();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [20];
  int   r;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h04, 32'h0,         1'b1, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 8'h04, 32'hDEADBEEF,  1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 8'h04, 32'h0,         1'b1, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b1, 8'h05, 32'h12345678,  1'b1, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 8'h05, 32'h0,         1'b1, 32'h12345678};
    tbl[5]  = '{1'b0, 1'b1, 8'h04, 32'h00000001,  1'b1, 32'hDEADBEEF};
    tbl[6]  = '{1'b0, 1'b0, 8'h04, 32'h0,         1'b1, 32'h00000001};
    tbl[7]  = '{1'b0, 1'b1, 8'h41, 32'hFFFFFFAB,  1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 8'h41, 32'h0,         1'b1, 32'h0000002B};
    tbl[9]  = '{1'b0, 1'b1, 8'h02, 32'hFFFFFFFF,  1'b1, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 8'h02, 32'h0,         1'b1, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 32'hFFFF0000,  1'b1, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'hFFFF0000};
    tbl[13] = '{1'b0, 1'b1, 8'h7F, 32'h0000003F,  1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 8'h7F, 32'h0,         1'b1, 32'h0000003F};
    tbl[15] = '{1'b0, 1'b1, 8'h80, 32'h12,        1'b0, 32'h0};
    tbl[16] = '{1'b0, 1'b0, 8'h80, 32'h0,         1'b1, 32'h0};
    tbl[17] = '{1'b0, 1'b0, 8'h0C, 32'h0,         1'b1, 32'h0};
    tbl[18] = '{1'b1, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0};
    tbl[19] = '{1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0};

    rst = 1'b1; irq = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; iack = 1'b0; ivn = '0;
    repeat (2) cycle();
    check("reset_ripl",    64'(si_int),     64'h0);
    check("reset_vec",     64'(si_vec),     64'h0);
    check("reset_present", 64'(si_present), 64'h1);

    // Register access vectors.
    for (int k = 0; k < 20; k++) begin
      rst = tbl[k].rst; cfg_we = tbl[k].we; cfg_addr = tbl[k].addr; cfg_wdata = tbl[k].wdata;
      cycle();
      if (tbl[k].chk) check($sformatf("tbl%0d_rdata", k), 64'(cfg_rdata), 64'(tbl[k].exp_rd));
      check($sformatf("tbl%0d_eiss", k),    64'(si_eiss),    64'h0);
      check($sformatf("tbl%0d_present", k), 64'(si_present), 64'h1);
    end
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = 8'h00;

    // Edge request and ack.
    wr(8'h04, 32'h8); wr(8'h00, 32'h8); wr(8'h43, 32'd5);
    irq[3] = 1'b1; cycle(); irq[3] = 1'b0;
    repeat (LAT - 2) cycle();
    check("edge_early_ripl", 64'(si_int), 64'h0);
    cycle();
    check("edge_ripl", 64'(si_int), 64'h5);
    check("edge_vec",  64'(si_vec), 64'h3);
    check("edge_off",  64'(si_off), 64'h30);
    iack = 1'b1; ivn = 6'd3; cycle(); iack = 1'b0;
    check("ack_hold_ripl", 64'(si_int), 64'h5);
    check("ack_pend3",     64'(pend[3]), 64'h0);
    cycle();
    check("ack_ripl", 64'(si_int), 64'h0);

    // Priority and tie between level channels.
    wr(8'h04, 32'h284); wr(8'h00, 32'h0); wr(8'h42, 32'd4); wr(8'h47, 32'd9); wr(8'h49, 32'd9);
    irq[2] = 1'b1; irq[7] = 1'b1; irq[9] = 1'b1;
    repeat (LAT) cycle();
    check("tie_vec",  64'(si_vec), 64'h7);
    check("tie_ripl", 64'(si_int), 64'h9);
    check("tie_off",  64'(si_off), 64'h70);
    irq[7] = 1'b0;
    repeat (LAT) cycle();
    check("drop_vec", 64'(si_vec), 64'h9);
    check("drop_off", 64'(si_off), 64'h90);

    // Ack on the same edge as a new rising edge keeps the request.
    wr(8'h00, 32'h20); wr(8'h04, 32'h20); wr(8'h45, 32'd7);
    irq[5] = 1'b1; cycle(); irq[5] = 1'b0;
    repeat (LAT - 1) cycle();
    check("simul_first_vec", 64'(si_vec), 64'h5);
    irq[5] = 1'b1;
    repeat (D) cycle();
    iack = 1'b1; ivn = 6'd5; cycle(); iack = 1'b0;
    check("simul_pend5", 64'(pend[5]), 64'h1);
    cycle();
    check("simul_vec",  64'(si_vec), 64'h5);
    check("simul_ripl", 64'(si_int), 64'h7);
    wr(8'h08, 32'h20);
    check("pendclr_pend5", 64'(pend[5]), 64'h0);
    check("pendclr_hold",  64'(si_int),  64'h7);
    cycle();
    check("pendclr_ripl", 64'(si_int), 64'h0);

    // High bank channel 40.
    irq = '0;
    wr(8'h04, 32'h0); wr(8'h01, 32'h100); wr(8'h05, 32'h100); wr(8'h68, 32'd63);
    irq[40] = 1'b1; cycle(); irq[40] = 1'b0;
    repeat (LAT - 1) cycle();
    check("hi_vec",  64'(si_vec), 64'd40);
    check("hi_ripl", 64'(si_int), 64'd63);
    check("hi_off",  64'(si_off), 64'h280);
    wr(8'h09, 32'h100);
    check("hi_pend40", 64'(pend[40]), 64'h0);
    cycle();
    check("hi_clr_ripl", 64'(si_int), 64'h0);

    // Level channel ignores acks and PEND writes.
    wr(8'h05, 32'h0); wr(8'h04, 32'h4);
    irq[2] = 1'b1;
    repeat (LAT) cycle();
    check("lvl_vec", 64'(si_vec), 64'h2);
    iack = 1'b1; ivn = 6'd2; cycle(); iack = 1'b0;
    wr(8'h08, 32'h4);
    cycle();
    check("lvl_pend2", 64'(pend[2]), 64'h1);
    check("lvl_ripl",  64'(si_int),  64'h4);

    // Priority change takes effect on the next selection, then reset mid-request.
    wr(8'h42, 32'd5);
    check("prio_chg_old", 64'(si_int), 64'h4);
    cycle();
    check("prio_chg_new", 64'(si_int), 64'h5);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rst_mid_ripl", 64'(si_int), 64'h0);
    check("rst_mid_vec",  64'(si_vec), 64'h0);
    for (int i = 0; i < 64; i++) begin
      cfg_addr = 8'(8'h40 + i);
      cycle();
      check($sformatf("rst_prio%0d", i), 64'(cfg_rdata), 64'h0);
    end

    // Randomized run against the model.
    irq = '0; rst = 1'b1; cycle(); rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      irq = irq ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      cfg_we = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 7);
      case (r)
        0: cfg_addr = 8'($urandom_range(0, 1));
        1: cfg_addr = 8'(4 + $urandom_range(0, 1));
        2: cfg_addr = 8'(8 + $urandom_range(0, 1));
        3, 4: cfg_addr = 8'(8'h40 + $urandom_range(0, 63));
        default: cfg_addr = 8'($urandom_range(0, 255));
      endcase
      cfg_wdata = $urandom;
      iack = ($urandom_range(0, 3) == 0);
      ivn  = ($urandom_range(0, 1) == 0) ? si_vec : 6'($urandom_range(0, 63));
      rst  = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
